mvm_driver: RTL and testbench

MVM_DRIVER -- requirements
Module: mvm_driver

---
 rtl/mvm_drv_pkg.sv | 30 +++
 rtl/drv_buffer.sv | 24 ++
 rtl/mvm_driver.sv | 177 +++++++++++++++++
 tb/tb_mvm_driver.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mvm_drv_pkg.sv
// rtl/mvm_drv_pkg.sv - shared FSM state type and buffer sizing for the MVM driver
// Ports: none (package).
package mvm_drv_pkg;

   localparam int DEF_K       = 8;
   localparam int MAT_WORDS   = DEF_K * DEF_K;
   localparam int TOTAL_WORDS = MAT_WORDS + DEF_K;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FILL,
      S_LDM,
      S_MDATA,
      S_LDV,
      S_VDATA,
      S_GO,
      S_WAIT,
      S_CAPT,
      S_DRAIN
   } drv_state_t;

   function automatic int mat_words(input int k);
      return k * k;
   endfunction

   function automatic int total_words(input int k);
      return k * k + k;
   endfunction

endpackage

// File: rtl/drv_buffer.sv
// rtl/drv_buffer.sv - word buffer with synchronous write and combinational read
// Ports: clk; we/waddr/wdata write port; raddr/rdata asynchronous read port.
module drv_buffer #(
   parameter int W     = 16,
   parameter int DEPTH = 72,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mvm_driver.sv
// rtl/mvm_driver.sv - sequences a K x K matrix and K-vector into an MVM and drains its result
// Ports: clk, reset (async, active low);
//        in_data/in_valid/in_ready - upstream words, matrix row-major then vector;
//        loadMatrix/loadVector/start/data_in - command pulses and word stream to the MVM;
//        done/data_out - MVM completion pulse and the K result words that follow it;
//        out_data/out_valid/out_ready - downstream result handshake; busy - not IDLE;
//        timeout_err - sticky WAIT timeout flag, present only with MVM_DRV_TIMEOUT_EN.
module mvm_driver
   import mvm_drv_pkg::*;
#(
   parameter int K       = DEF_K,
   parameter int B       = 16,
   parameter int TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic signed [B-1:0]   in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  loadMatrix,
   output logic                  loadVector,
   output logic                  start,
   output logic signed [B-1:0]   data_in,
   input  logic                  done,
   input  logic signed [2*B-1:0] data_out,
   output logic [2*B-1:0]        out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy
`ifdef MVM_DRV_TIMEOUT_EN
   ,
   output logic                  timeout_err
`endif
);

   // The default build takes the package constants directly.
   localparam int MW  = (K == DEF_K) ? MAT_WORDS   : mat_words(K);
   localparam int TW  = (K == DEF_K) ? TOTAL_WORDS : total_words(K);
   localparam int CW  = (TW > 1) ? $clog2(TW) : 1;
   localparam int RAW = (K > 1) ? $clog2(K) : 1;

   drv_state_t     state, next_state;
   logic [CW-1:0]  cnt;
   logic           cnt_step, cnt_last;
   logic [CW-1:0]  in_raddr;
   logic [B-1:0]   in_rdata;
   logic [2*B-1:0] res_rdata;
   logic           in_we, res_we;
   logic           tmo_hit;

   assign in_we    = in_ready & in_valid;
   assign res_we   = (state == S_CAPT);
   // Vector words sit directly after the matrix words in the input buffer.
   assign in_raddr = (state == S_VDATA) ? CW'(MW) + cnt : cnt;

   drv_buffer #(.W(B), .DEPTH(TW)) u_in_buf (
      .clk   (clk),
      .we    (in_we),
      .waddr (cnt),
      .wdata (in_data),
      .raddr (in_raddr),
      .rdata (in_rdata)
   );

   drv_buffer #(.W(2*B), .DEPTH(K)) u_res_buf (
      .clk   (clk),
      .we    (res_we),
      .waddr (cnt[RAW-1:0]),
      .wdata (data_out),
      .raddr (cnt[RAW-1:0]),
      .rdata (res_rdata)
   );

`ifdef MVM_DRV_TIMEOUT_EN
   localparam int TCW = $clog2(TIMEOUT + 1);
   logic [TCW-1:0] tmo_cnt;

   // tmo_cnt equals the number of cycles elapsed since the start pulse,
   // so the flag appears exactly TIMEOUT cycles after start.
   assign tmo_hit = (state == S_WAIT) && !done && (tmo_cnt >= TCW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tmo_cnt     <= '0;
         timeout_err <= 1'b0;
      end else begin
         tmo_cnt <= (state == S_WAIT) ? tmo_cnt + 1'b1 : TCW'(1);
         if (tmo_hit) timeout_err <= 1'b1;
      end
   end
`else
   logic unused_tmo;
   assign tmo_hit    = 1'b0;
   assign unused_tmo = (TIMEOUT == 0);
`endif

   // One shared address counter; it steps per accepted/streamed word and
   // wraps to 0 on the last word of each counting state.
   always_comb begin
      cnt_step = 1'b0;
      cnt_last = 1'b0;
      case (state)
         S_IDLE, S_FILL: begin
            cnt_step = in_valid;
            cnt_last = (cnt == CW'(TW - 1));
         end
         S_MDATA: begin
            cnt_step = 1'b1;
            cnt_last = (cnt == CW'(MW - 1));
         end
         S_VDATA, S_CAPT: begin
            cnt_step = 1'b1;
            cnt_last = (cnt == CW'(K - 1));
         end
         S_DRAIN: begin
            cnt_step = out_ready;
            cnt_last = (cnt == CW'(K - 1));
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)        cnt <= '0;
      else if (cnt_step) cnt <= cnt_last ? '0 : cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (in_valid)             next_state = S_FILL;
         S_FILL:  if (in_valid && cnt_last) next_state = S_LDM;
         S_LDM:                             next_state = S_MDATA;
         S_MDATA: if (cnt_last)             next_state = S_LDV;
         S_LDV:                             next_state = S_VDATA;
         S_VDATA: if (cnt_last)             next_state = S_GO;
         S_GO:                              next_state = S_WAIT;
         S_WAIT: begin
            if (done)         next_state = S_CAPT;
            else if (tmo_hit) next_state = S_IDLE;
         end
         S_CAPT:  if (cnt_last)              next_state = S_DRAIN;
         S_DRAIN: if (out_ready && cnt_last) next_state = S_IDLE;
         default:                            next_state = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready   = 1'b0;
      loadMatrix = 1'b0;
      loadVector = 1'b0;
      start      = 1'b0;
      data_in    = '0;
      out_valid  = 1'b0;
      out_data   = '0;
      busy       = (state != S_IDLE);
      case (state)
         // Gated by reset so in_ready is 0 while reset is held.
         S_IDLE, S_FILL:   in_ready   = reset;
         S_LDM:            loadMatrix = 1'b1;
         S_MDATA, S_VDATA: data_in    = in_rdata;
         S_LDV:            loadVector = 1'b1;
         S_GO:             start      = 1'b1;
         S_DRAIN: begin
            out_valid = 1'b1;
            out_data  = res_rdata;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mvm_driver.sv
// tb/tb_mvm_driver.sv - directed self-checking bench for mvm_driver
module tb_mvm_driver;

   localparam int K   = 8;
   localparam int MW  = K * K;
   localparam int TW  = MW + K;
   localparam int TMO = 20;

   logic               clk;
   logic               reset;
   logic signed [15:0] in_data;
   logic               in_valid;
   logic               in_ready;
   logic               loadMatrix, loadVector, start;
   logic signed [15:0] data_in;
   logic               done;
   logic signed [31:0] data_out;
   logic [31:0]        out_data;
   logic               out_valid;
   logic               out_ready;
   logic               busy;
`ifdef MVM_DRV_TIMEOUT_EN
   logic               timeout_err;
`endif

   int total;
   int bad;

   logic signed [15:0] words   [TW];
   logic signed [15:0] dm      [TW];
   logic [31:0]        exp_out [K];

   mvm_driver #(.K(K), .B(16), .TIMEOUT(TMO)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .loadMatrix (loadMatrix),
      .loadVector (loadVector),
      .start      (start),
      .data_in    (data_in),
      .done       (done),
      .data_out   (data_out),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy)
`ifdef MVM_DRV_TIMEOUT_EN
      ,
      .timeout_err(timeout_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   // Entered at #1 after a clock edge; returns at #1 after the edge that
   // accepts the last word (the LDM cycle).
   task automatic do_fill(input bit gaps, input int spur_at);
      int rdy_err;
      rdy_err = 0;
      for (int i = 0; i < TW; i++) begin
         if (gaps && i > 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         in_data  = words[i];
         done     = (i == spur_at);
         @(negedge clk);
         if (!in_ready) rdy_err++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      done     = 1'b0;
      check_eq("fill_ready", rdy_err, 0);
   endtask

   // Checks the command/word stream cycle by cycle; ends at the negedge of the start cycle.
   task automatic run_stream();
      int e_cmd, e_m, e_v;
      e_cmd = 0; e_m = 0; e_v = 0;
      @(negedge clk);
      if (!(loadMatrix && !loadVector && !start && data_in == 0)) e_cmd++;
      for (int i = 0; i < MW; i++) begin
         @(negedge clk);
         dm[i] = data_in;
         if (data_in !== words[i] || loadMatrix || loadVector || start) e_m++;
      end
      @(negedge clk);
      if (!(loadVector && !loadMatrix && !start && data_in == 0)) e_cmd++;
      for (int i = MW; i < TW; i++) begin
         @(negedge clk);
         dm[i] = data_in;
         if (data_in !== words[i] || loadMatrix || loadVector || start) e_v++;
      end
      @(negedge clk);
      if (!(start && !loadMatrix && !loadVector && data_in == 0)) e_cmd++;
      check_eq("cmd_pulses", e_cmd, 0);
      check_eq("mdata_words", e_m, 0);
      check_eq("vdata_words", e_v, 0);
   endtask

   // Model MVM: multiplies what it was actually sent, pulses done, streams K results.
   task automatic run_mvm();
      int acc;
      logic signed [31:0] y [K];
      for (int i = 0; i < K; i++) begin
         acc = 0;
         for (int j = 0; j < K; j++) acc += int'(dm[i*K+j]) * int'(dm[MW+j]);
         y[i] = acc;
      end
      repeat (3) @(posedge clk);
      #1;
      done = 1'b1;
      @(posedge clk); #1;
      done = 1'b0;
      for (int i = 0; i < K; i++) begin
         data_out = y[i];
         @(posedge clk); #1;
      end
      data_out = '0;
   endtask

   task automatic compute_exp();
      int acc;
      for (int i = 0; i < K; i++) begin
         acc = 0;
         for (int j = 0; j < K; j++) acc += int'(words[i*K+j]) * int'(words[MW+j]);
         exp_out[i] = acc;
      end
   endtask

   task automatic do_drain(input int stall_e, input int stall_n);
      int hold_err;
      for (int e = 0; e < K; e++) begin
         if (e == stall_e) begin
            hold_err  = 0;
            out_ready = 1'b0;
            for (int c = 0; c < stall_n; c++) begin
               @(negedge clk);
               if (!out_valid || out_data !== exp_out[e]) hold_err++;
               @(posedge clk); #1;
            end
            check_eq("stall_hold", hold_err, 0);
            out_ready = 1'b1;
         end
         @(negedge clk);
         check_eq($sformatf("out%0d_valid", e), out_valid, 1);
         check_eq($sformatf("out%0d_data", e), out_data, exp_out[e]);
         @(posedge clk); #1;
      end
      @(negedge clk);
      check_eq("drain_idle", {out_valid, busy, in_ready}, 3'b001);
   endtask

   initial begin
      total = 0; bad = 0;
      reset = 1'b0; in_valid = 1'b0; in_data = '0; done = 1'b0;
      data_out = '0; out_ready = 1'b1;

      repeat (2) @(negedge clk);
      check_eq("reset_outs", {in_ready, out_valid, loadMatrix, loadVector, start, busy,
                              data_in, out_data}, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check_eq("idle_ready_busy", {in_ready, busy}, 2'b10);

      // Identity matrix, vector 1..8, no gaps -> results 1..8.
      @(posedge clk); #1;
      for (int i = 0; i < MW; i++) words[i] = ((i / K) == (i % K)) ? 16'sd1 : 16'sd0;
      for (int j = 0; j < K; j++) words[MW+j] = 16'(j + 1);
      for (int i = 0; i < K; i++) exp_out[i] = 32'(i + 1);
      do_fill(1'b0, -1);
      run_stream();
      run_mvm();
      do_drain(-1, 0);

      // Gapped fill, signed band matrix, stall on entry 3 for 5 cycles.
      @(posedge clk); #1;
      for (int i = 0; i < MW; i++)
         words[i] = ((i / K) == (i % K)) ? -16'sd1 : (((i % K) == (i / K) + 1) ? 16'sd2 : 16'sd0);
      for (int j = 0; j < K; j++) words[MW+j] = 16'(3 * j - 5);
      compute_exp();
      do_fill(1'b1, -1);
      run_stream();
      run_mvm();
      do_drain(3, 5);

      // Reset mid-MDATA, then a fresh load with a spurious done during FILL.
      @(posedge clk); #1;
      for (int i = 0; i < TW; i++) words[i] = 16'(i + 1);
      do_fill(1'b0, -1);
      repeat (12) @(negedge clk);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check_eq("midrst_outs", {in_ready, out_valid, loadMatrix, loadVector, start, busy,
                               data_in, out_data}, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check_eq("midrst_idle", {in_ready, busy}, 2'b10);
      @(posedge clk); #1;
      for (int i = 0; i < MW; i++) words[i] = 16'((i / K) + (i % K) - 4);
      for (int j = 0; j < K; j++) words[MW+j] = 16'(j - 3);
      compute_exp();
      do_fill(1'b0, 20);
      run_stream();
      run_mvm();
      do_drain(-1, 0);

`ifdef MVM_DRV_TIMEOUT_EN
      @(posedge clk); #1;
      do_fill(1'b0, -1);
      run_stream();
      repeat (TMO - 1) @(negedge clk);
      check_eq("tmo_early", timeout_err, 0);
      @(negedge clk);
      check_eq("tmo_err", timeout_err, 1);
      check_eq("tmo_busy", busy, 0);
      repeat (3) @(negedge clk);
      check_eq("tmo_sticky", timeout_err, 1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
